// File: rtl/channel_deserializer.sv
// Splits a MAC RX stream into per-channel payload frames, framed by a header word.
// Statistics counters are built only when SFP_RX_STATS_EN is defined.
module channel_deserializer #(
    parameter int unsigned M_AXIS_TDATA_WIDTH = 64,
    parameter int unsigned MAX_WORDS          = 256
) (
    input  logic                            RX_ACLK,
    input  logic                            RX_ARESETN,
    input  logic [M_AXIS_TDATA_WIDTH-1:0]   RX_S_AXIS_TDATA,
    input  logic [M_AXIS_TDATA_WIDTH/8-1:0] RX_S_AXIS_TKEEP,
    input  logic                            RX_S_AXIS_TUSER,
    input  logic                            RX_S_AXIS_TLAST,
    input  logic                            RX_S_AXIS_TVALID,
    output logic [M_AXIS_TDATA_WIDTH-1:0]   M_AXIS_TDATA,
    output logic [7:0]                      M_AXIS_TVALID,
    output logic                            M_AXIS_TLAST,
    output logic                            M_AXIS_TUSER,
    output logic [31:0]                     STAT_FRAME_CNT,
    output logic [31:0]                     STAT_ERR_CNT,
    output logic [31:0]                     STAT_DROP_CNT
);

    localparam int unsigned DW     = M_AXIS_TDATA_WIDTH;
    localparam int unsigned KW     = DW / 8;
    localparam int unsigned NUM_CH = 8;
    localparam int unsigned CH_W   = 3;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned STAT_W = 32;

    typedef enum logic [1:0] {IDLE, PAYLOAD, DROP} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CH_W-1:0]  ch;
    logic             sticky;

    logic             word_err_c;
    logic [CNT_W-1:0] hdr_len_c;
    logic             hdr_ok_c;
    logic             frame_end_c;
    logic             frame_err_c;

    // Header decode and end-of-frame classification for the current input word
    always_comb begin
        word_err_c  = RX_S_AXIS_TUSER | (RX_S_AXIS_TKEEP != {KW{1'b1}});
        hdr_len_c   = RX_S_AXIS_TDATA[15:0];
        hdr_ok_c    = (RX_S_AXIS_TDATA[63:48] == 16'h5346) &&
                      (hdr_len_c != '0) &&
                      (32'(hdr_len_c) <= MAX_WORDS);
        frame_end_c = (state == PAYLOAD) && RX_S_AXIS_TVALID &&
                      (RX_S_AXIS_TLAST || (cnt == CNT_W'(1)));
        // Only an exact-length frame can be clean; short and long frames are errors
        frame_err_c = !(RX_S_AXIS_TLAST && (cnt == CNT_W'(1))) || sticky || word_err_c;
    end

    always_ff @(posedge RX_ACLK or negedge RX_ARESETN) begin
        if (!RX_ARESETN) begin
            state         <= IDLE;
            cnt           <= '0;
            ch            <= '0;
            sticky        <= 1'b0;
            M_AXIS_TDATA  <= '0;
            M_AXIS_TVALID <= '0;
            M_AXIS_TLAST  <= 1'b0;
            M_AXIS_TUSER  <= 1'b0;
        end else begin
            M_AXIS_TVALID <= '0;
            M_AXIS_TLAST  <= 1'b0;
            M_AXIS_TUSER  <= 1'b0;
            if (RX_S_AXIS_TVALID) begin
                case (state)
                    IDLE: begin
                        if (!RX_S_AXIS_TLAST && hdr_ok_c) begin
                            ch     <= RX_S_AXIS_TDATA[42:40];
                            cnt    <= hdr_len_c;
                            sticky <= 1'b0;
                            state  <= PAYLOAD;
                        end else if (!RX_S_AXIS_TLAST) begin
                            state <= DROP;
                        end
                    end
                    PAYLOAD: begin
                        M_AXIS_TDATA  <= RX_S_AXIS_TDATA;
                        M_AXIS_TVALID <= {{(NUM_CH-1){1'b0}}, 1'b1} << ch;
                        cnt           <= cnt - CNT_W'(1);
                        sticky        <= sticky | word_err_c;
                        if (frame_end_c) begin
                            M_AXIS_TLAST <= 1'b1;
                            M_AXIS_TUSER <= frame_err_c;
                            state        <= RX_S_AXIS_TLAST ? IDLE : DROP;
                        end
                    end
                    DROP: begin
                        if (RX_S_AXIS_TLAST) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef SFP_RX_STATS_EN
    logic drop_c;

    assign drop_c = (state == IDLE) && RX_S_AXIS_TVALID && (RX_S_AXIS_TLAST || !hdr_ok_c);

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == {STAT_W{1'b1}}) ? v : v + STAT_W'(1);
    endfunction

    // Saturating statistics counters
    always_ff @(posedge RX_ACLK or negedge RX_ARESETN) begin
        if (!RX_ARESETN) begin
            STAT_FRAME_CNT <= '0;
            STAT_ERR_CNT   <= '0;
            STAT_DROP_CNT  <= '0;
        end else begin
            if (frame_end_c) begin
                STAT_FRAME_CNT <= sat_inc(STAT_FRAME_CNT);
            end
            if (frame_end_c && frame_err_c) begin
                STAT_ERR_CNT <= sat_inc(STAT_ERR_CNT);
            end
            if (drop_c) begin
                STAT_DROP_CNT <= sat_inc(STAT_DROP_CNT);
            end
        end
    end
`else
    assign STAT_FRAME_CNT = '0;
    assign STAT_ERR_CNT   = '0;
    assign STAT_DROP_CNT  = '0;
`endif

endmodule

// File: tb/tb_channel_deserializer.sv
// Randomized bench for channel_deserializer against a frame-level reference model.
module tb_channel_deserializer;

    localparam int unsigned MAXW = 256;

    logic        RX_ACLK = 1'b0;
    logic        RX_ARESETN;
    logic [63:0] RX_S_AXIS_TDATA;
    logic [7:0]  RX_S_AXIS_TKEEP;
    logic        RX_S_AXIS_TUSER;
    logic        RX_S_AXIS_TLAST;
    logic        RX_S_AXIS_TVALID;
    logic [63:0] M_AXIS_TDATA;
    logic [7:0]  M_AXIS_TVALID;
    logic        M_AXIS_TLAST;
    logic        M_AXIS_TUSER;
    logic [31:0] STAT_FRAME_CNT;
    logic [31:0] STAT_ERR_CNT;
    logic [31:0] STAT_DROP_CNT;

    int total = 0;
    int bad   = 0;
    int exp_frame = 0;
    int exp_err   = 0;
    int exp_drop  = 0;

    channel_deserializer #(.M_AXIS_TDATA_WIDTH(64), .MAX_WORDS(MAXW)) dut (
        .RX_ACLK         (RX_ACLK),
        .RX_ARESETN      (RX_ARESETN),
        .RX_S_AXIS_TDATA (RX_S_AXIS_TDATA),
        .RX_S_AXIS_TKEEP (RX_S_AXIS_TKEEP),
        .RX_S_AXIS_TUSER (RX_S_AXIS_TUSER),
        .RX_S_AXIS_TLAST (RX_S_AXIS_TLAST),
        .RX_S_AXIS_TVALID(RX_S_AXIS_TVALID),
        .M_AXIS_TDATA    (M_AXIS_TDATA),
        .M_AXIS_TVALID   (M_AXIS_TVALID),
        .M_AXIS_TLAST    (M_AXIS_TLAST),
        .M_AXIS_TUSER    (M_AXIS_TUSER),
        .STAT_FRAME_CNT  (STAT_FRAME_CNT),
        .STAT_ERR_CNT    (STAT_ERR_CNT),
        .STAT_DROP_CNT   (STAT_DROP_CNT)
    );

    always #5 RX_ACLK = ~RX_ACLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_stats(input string tag);
`ifdef SFP_RX_STATS_EN
        check({tag, "_frame_cnt"}, 64'(STAT_FRAME_CNT), 64'(exp_frame));
        check({tag, "_err_cnt"},   64'(STAT_ERR_CNT),   64'(exp_err));
        check({tag, "_drop_cnt"},  64'(STAT_DROP_CNT),  64'(exp_drop));
`else
        check({tag, "_frame_cnt"}, 64'(STAT_FRAME_CNT), 64'd0);
        check({tag, "_err_cnt"},   64'(STAT_ERR_CNT),   64'd0);
        check({tag, "_drop_cnt"},  64'(STAT_DROP_CNT),  64'd0);
`endif
    endtask

    // Drive one input cycle (entered at negedge) and check the registered response after the edge
    task automatic cycle(input logic v, input logic [63:0] d, input logic [7:0] k, input logic u,
                         input logic l, input logic fwd, input logic [7:0] ev,
                         input logic [63:0] ed, input logic el, input logic eu);
        RX_S_AXIS_TVALID = v;
        RX_S_AXIS_TDATA  = d;
        RX_S_AXIS_TKEEP  = k;
        RX_S_AXIS_TUSER  = u;
        RX_S_AXIS_TLAST  = l;
        @(posedge RX_ACLK);
        #1;
        check("out_tvalid", 64'(M_AXIS_TVALID), 64'(ev));
        if (fwd) check("out_tdata", M_AXIS_TDATA, ed);
        check("out_tlast", 64'(M_AXIS_TLAST), 64'(el));
        check("out_tuser", 64'(M_AXIS_TUSER), 64'(eu));
        RX_S_AXIS_TVALID = 1'b0;
        @(negedge RX_ACLK);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            cycle(1'b0, 64'(i), 8'hFF, 1'b0, 1'b0, 1'b0, 8'h00, 64'd0, 1'b0, 1'b0);
    endtask

    task automatic maybe_gap(input int gap_pct);
        if (int'($urandom_range(99)) < gap_pct) idle(int'($urandom_range(1, 2)));
    endtask

    // Frame-level model: header + len payload words; outcome decided from N vs len and word errors
    task automatic send_frame(input logic [15:0] magic, input logic [2:0] ch, input logic [15:0] n,
                              input int len, input int err_pct, input bit user_last,
                              input int gap_pct);
        logic [63:0] data [16];
        logic [7:0]  keep [16];
        logic        user [16];
        logic [63:0] hdr;
        bit          hdr_ok;
        bit          fu;
        bit          fwd;
        bit          last_out;
        int          k;
        for (int i = 0; i < len; i++) begin
            data[i] = {$urandom, $urandom};
            keep[i] = 8'hFF;
            user[i] = 1'b0;
            if (int'($urandom_range(99)) < err_pct) begin
                if ($urandom_range(1) == 0) keep[i] = 8'($urandom_range(254));
                else                        user[i] = 1'b1;
            end
            if (user_last && i == len - 1) user[i] = 1'b1;
        end
        hdr_ok = (magic == 16'h5346) && (n >= 1) && (32'(n) <= MAXW);
        k  = (len < int'(n)) ? len : int'(n);
        fu = (len != int'(n));
        for (int i = 0; i < k; i++) fu |= (keep[i] != 8'hFF) || user[i];
        hdr = {$urandom, $urandom};
        hdr[63:48] = magic;
        hdr[42:40] = ch;
        hdr[15:0]  = n;
        cycle(1'b1, hdr, 8'hFF, 1'b0, len == 0, 1'b0, 8'h00, 64'd0, 1'b0, 1'b0);
        maybe_gap(gap_pct);
        for (int i = 0; i < len; i++) begin
            fwd      = hdr_ok && (i < k);
            last_out = fwd && (i == k - 1);
            cycle(1'b1, data[i], keep[i], user[i], i == len - 1, fwd,
                  fwd ? (8'(1) << ch) : 8'h00, data[i], last_out, last_out && fu);
            maybe_gap(gap_pct);
        end
        if (len == 0 || !hdr_ok) begin
            exp_drop++;
        end else begin
            exp_frame++;
            if (fu) exp_err++;
        end
    endtask

    function automatic logic [15:0] bad_magic();
        logic [15:0] m;
        m = 16'($urandom);
        if (m == 16'h5346) m = m ^ 16'h0001;
        return m;
    endfunction

    initial begin
        logic [15:0] n;
        int          len;
        int          r;
        RX_ARESETN       = 1'b0;
        RX_S_AXIS_TVALID = 1'b0;
        RX_S_AXIS_TDATA  = '0;
        RX_S_AXIS_TKEEP  = 8'hFF;
        RX_S_AXIS_TUSER  = 1'b0;
        RX_S_AXIS_TLAST  = 1'b0;
        repeat (3) @(negedge RX_ACLK);
        check("rst_tdata",  M_AXIS_TDATA, 64'd0);
        check("rst_tvalid", 64'(M_AXIS_TVALID), 64'd0);
        check("rst_tlast",  64'(M_AXIS_TLAST), 64'd0);
        check("rst_tuser",  64'(M_AXIS_TUSER), 64'd0);
        check_stats("rst");
        RX_ARESETN = 1'b1;
        @(negedge RX_ACLK);

        // Exact-length frame, then gapped frame with error on last word
        send_frame(16'h5346, 3'd3, 16'd4, 4, 0, 1'b0, 0);
        check_stats("basic");
        send_frame(16'h5346, 3'd3, 16'd4, 4, 0, 1'b1, 100);
        check_stats("gapped_err");
        // Short frame, long frame, bad headers, runt
        send_frame(16'h5346, 3'd5, 16'd4, 2, 0, 1'b0, 0);
        check_stats("short");
        send_frame(16'h5346, 3'd0, 16'd2, 4, 0, 1'b0, 0);
        check_stats("long");
        send_frame(16'h0000, 3'd1, 16'd4, 3, 0, 1'b0, 0);
        send_frame(16'h5346, 3'd1, 16'd1, 0, 0, 1'b0, 0);
        check_stats("bad_magic_runt");
        send_frame(16'h5346, 3'd2, 16'd0, 2, 0, 1'b0, 0);
        send_frame(16'h5346, 3'd2, 16'(MAXW + 1), 2, 0, 1'b0, 0);
        check_stats("bad_len");
        send_frame(16'h5346, 3'd7, 16'(MAXW), 1, 0, 1'b0, 0);
        send_frame(16'h5346, 3'd6, 16'd1, 1, 0, 1'b0, 0);
        check_stats("len_bounds");

        // Reset pulse in the middle of a payload
        cycle(1'b1, {16'h5346, 5'd0, 3'd2, 24'd0, 16'd4}, 8'hFF, 1'b0, 1'b0, 1'b0,
              8'h00, 64'd0, 1'b0, 1'b0);
        cycle(1'b1, 64'hA5A5_0000_1111_2222, 8'hFF, 1'b0, 1'b0, 1'b1,
              8'h04, 64'hA5A5_0000_1111_2222, 1'b0, 1'b0);
        RX_ARESETN = 1'b0;
        #1;
        exp_frame = 0;
        exp_err   = 0;
        exp_drop  = 0;
        check("midrst_tvalid", 64'(M_AXIS_TVALID), 64'd0);
        check("midrst_tdata",  M_AXIS_TDATA, 64'd0);
        check("midrst_tlast",  64'(M_AXIS_TLAST), 64'd0);
        check_stats("midrst");
        @(negedge RX_ACLK);
        RX_ARESETN = 1'b1;
        send_frame(16'h0000, 3'd2, 16'd4, 2, 0, 1'b0, 0);
        send_frame(16'h5346, 3'd4, 16'd3, 3, 0, 1'b0, 0);
        check_stats("after_rst");

        // Randomized traffic
        for (int f = 0; f < 300; f++) begin
            r = int'($urandom_range(99));
            if (r < 5)       n = 16'd0;
            else if (r < 10) n = 16'(MAXW + 1);
            else if (r < 13) n = 16'(MAXW);
            else             n = 16'($urandom_range(1, 8));
            r = int'($urandom_range(99));
            if (r < 10)                     len = 0;
            else if (r < 70 && n <= 16'd12) len = int'(n);
            else                            len = int'($urandom_range(1, 12));
            send_frame(($urandom_range(9) == 0) ? bad_magic() : 16'h5346,
                       3'($urandom_range(7)), n, len, 10, 1'b0, 30);
            if (f % 20 == 19) check_stats("rand");
        end
        check_stats("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/channel_deserializer.md
CHANNEL_DESERIALIZER -- requirements
Module: channel_deserializer

Interface
REQ-001 SHALL have parameter M_AXIS_TDATA_WIDTH, 64, width of RX input and channel output data (only 64 supported).
REQ-002 SHALL have parameter MAX_WORDS, 256, largest accepted payload length in words (1..65535).
REQ-003 SHALL have port RX_ACLK  in  1  sole clock; all logic is rising-edge.
REQ-004 SHALL have port RX_ARESETN  in  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have ports RX_S_AXIS_TDATA in 64, RX_S_AXIS_TKEEP in 8, RX_S_AXIS_TUSER in 1 (MAC bad-frame flag), RX_S_AXIS_TLAST in 1, RX_S_AXIS_TVALID in 1; there is no TREADY (MAC cannot stall).
REQ-006 SHALL have port M_AXIS_TDATA  out  64  payload word shared by all channels.
REQ-007 SHALL have port M_AXIS_TVALID  out  8  one-hot channel valid; bit k qualifies data for channel k.
REQ-008 SHALL have ports M_AXIS_TLAST  out  1  last payload word of frame, and M_AXIS_TUSER  out  1  frame error, valid only with TLAST.
REQ-009 SHALL have ports STAT_FRAME_CNT, STAT_ERR_CNT, STAT_DROP_CNT  out  32 each  statistics (see Configuration).

Function
REQ-010 SHALL accept a frame as one header word followed by N payload words, RX_S_AXIS_TLAST on the final word.
REQ-011 Header SHALL be: [63:48] magic 16'h5346, [42:40] channel id, [15:0] N; all other bits ignored.
REQ-012 SHALL implement FSM states IDLE, PAYLOAD, DROP; reset state IDLE.
REQ-013 IDLE, TVALID with TLAST: runt frame; increment DROP_CNT; stay IDLE.
REQ-014 IDLE, TVALID without TLAST: magic match and 1<=N<=MAX_WORDS -> latch channel, load counter with N, clear sticky error, go PAYLOAD; otherwise increment DROP_CNT, go DROP.
REQ-015 Header word SHALL NOT be forwarded.
REQ-016 PAYLOAD, each TVALID word: forward TDATA, drive M_AXIS_TVALID = 1<<channel exactly one cycle later (latency 1, registered); decrement counter.
REQ-017 Sticky error SHALL set on any payload word with TKEEP != 8'hFF or TUSER = 1.
REQ-018 PAYLOAD, TLAST with counter==1: output TLAST=1, TUSER=sticky|TUSER|(TKEEP!=FF); increment FRAME_CNT, also ERR_CNT if TUSER out; go IDLE.
REQ-019 PAYLOAD, TLAST with counter>1 (short frame): output word with TLAST=1, TUSER=1; increment FRAME_CNT and ERR_CNT; go IDLE.
REQ-020 PAYLOAD, counter==1 without TLAST (long frame): output word with TLAST=1, TUSER=1; increment FRAME_CNT and ERR_CNT; go DROP.
REQ-021 DROP: discard all words; on TVALID&TLAST go IDLE.
REQ-022 Cycles with TVALID=0 SHALL not change state, counter or outputs other than deasserting M_AXIS_TVALID.
REQ-023 M_AXIS_TVALID SHALL be all-zero whenever no word is forwarded; TLAST/TUSER SHALL be 0 unless a bit of M_AXIS_TVALID is 1.
REQ-024 Statistics counters SHALL saturate at 32'hFFFFFFFF, never wrap.

Reset
REQ-025 On RX_ARESETN low SHALL immediately force: state IDLE, counter 0, sticky 0, M_AXIS_TDATA 0, M_AXIS_TVALID 0, TLAST 0, TUSER 0, all STAT_* 0.
REQ-026 Reset mid-frame SHALL abandon the frame with no TLAST emitted; after release the remaining words of that frame are parsed as a new header (and normally dropped via REQ-014).

Configuration
REQ-027 Macro SFP_RX_STATS_EN defined: STAT_FRAME_CNT, STAT_ERR_CNT, STAT_DROP_CNT implemented per REQ-013..024.
REQ-028 Macro SFP_RX_STATS_EN undefined: counter registers not built, STAT_* ports tied to 0; datapath behaviour identical.

Verification
REQ-029 Header {5346, ch=3, N=4} + 4 words D0..D3 (TLAST on D3, TKEEP FF, TUSER 0) -> D0..D3 out one cycle later, TVALID=8'h08, TLAST only on D3, TUSER 0, FRAME_CNT=1.
REQ-030 Same frame with TVALID gaps between every word and TUSER=1 on D3 -> identical data order, TLAST on D3 with TUSER=1, ERR_CNT=1.
REQ-031 Header ch=5 N=4, TLAST on 2nd payload word -> 2 words out on TVALID=8'h20, 2nd with TLAST=1 TUSER=1; next frame parsed normally.
REQ-032 Header ch=0 N=2 + 4 payload words -> 2 words out, 2nd TLAST=1 TUSER=1; words 3-4 discarded; ERR_CNT=1, DROP_CNT=0.
REQ-033 Header magic 16'h0000 + 3 words; then single-word frame (runt) -> no output, DROP_CNT=2; N=0 and N=MAX_WORDS+1 headers also dropped.
REQ-034 RX_ARESETN pulsed low mid-payload -> outputs 0 in same cycle, no TLAST, a following valid frame delivered correctly; with macro undefined all STAT_* read 0.
